// File: rtl/copier_pkg.sv
// Shared types and 7-segment codes for the copier controller.
package copier_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COPYING  = 3'd1,
    JAMMED   = 3'd2,
    NO_PAPER = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [6:0] SEG_IDLE     = 7'b0111111;
  localparam logic [6:0] SEG_COPYING  = 7'b0000110;
  localparam logic [6:0] SEG_JAMMED   = 7'b1011011;
  localparam logic [6:0] SEG_NO_PAPER = 7'b1001111;
  localparam logic [6:0] SEG_DONE     = 7'b1100110;

  function automatic logic [6:0] seg_of(state_t s);
    case (s)
      IDLE:     return SEG_IDLE;
      COPYING:  return SEG_COPYING;
      JAMMED:   return SEG_JAMMED;
      NO_PAPER: return SEG_NO_PAPER;
      DONE:     return SEG_DONE;
      default:  return SEG_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/copier_page_timer.sv
// Per-page cycle counter; wrap is high on the enabled cycle that completes a page.
module copier_page_timer #(
  parameter int unsigned PAGE_CYCLES = 4,
  parameter int unsigned CW          = $clog2(PAGE_CYCLES + 1)
) (
  input  logic          clk_2,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  output logic          wrap,
  output logic [CW-1:0] page_cnt
);

  assign wrap = enable && (page_cnt == CW'(PAGE_CYCLES - 1));

  always_ff @(posedge clk_2) begin
    if (reset || clear) begin
      page_cnt <= '0;
    end else if (enable) begin
      page_cnt <= wrap ? '0 : page_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/copier_ctrl.sv
// Copier job FSM: counts pages down, suspends on jam / paper-out / open lid
// without losing the remaining count.
module copier_ctrl
  import copier_pkg::*;
#(
  parameter int unsigned QTY_W       = 4,
  parameter int unsigned PAGE_CYCLES = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [QTY_W-1:0] qty,
  input  logic             paper,
  input  logic             jam,
  input  logic             lid_closed,
  output logic [2:0]       state_o,
  output logic             copying,
  output logic             no_paper,
  output logic             jammed,
  output logic             done,
  output logic             page_tick,
  output logic [QTY_W-1:0] remaining,
  output logic [6:0]       seg
);

  localparam int unsigned CW = $clog2(PAGE_CYCLES + 1);

  state_t           state_q, state_d;
  logic [QTY_W-1:0] rem_q, rem_d;
  logic             lid_opened_q, lid_opened_d;
  logic             tick_d;
  logic             cnt_en, cnt_clr, wrap;
  logic [CW-1:0]    page_cnt;

  copier_page_timer #(.PAGE_CYCLES(PAGE_CYCLES), .CW(CW)) u_timer (
    .clk_2    (clk_2),
    .reset    (reset),
    .enable   (cnt_en),
    .clear    (cnt_clr),
    .wrap     (wrap),
    .page_cnt (page_cnt)
  );

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      lid_opened_q <= 1'b0;
      page_tick    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      lid_opened_q <= lid_opened_d;
      page_tick    <= tick_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    lid_opened_d = lid_opened_q;
    tick_d       = 1'b0;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;
    if (cancel) begin
      state_d      = IDLE;
      rem_d        = '0;
      lid_opened_d = 1'b0;
      cnt_clr      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && qty != '0) begin
            rem_d   = qty;
            cnt_clr = 1'b1;
            if (jam)         state_d = JAMMED;
            else if (!paper) state_d = NO_PAPER;
            else             state_d = COPYING;
          end
        end
        COPYING: begin
          if (jam) begin
            state_d = JAMMED;
            cnt_clr = 1'b1;
          end else if (!paper) begin
            state_d = NO_PAPER;
            cnt_clr = 1'b1;
          end else if (lid_closed) begin
            cnt_en = 1'b1;
            if (wrap) begin
              rem_d  = rem_q - QTY_W'(1);
              tick_d = 1'b1;
              if (rem_q == QTY_W'(1)) state_d = DONE;
            end
          end
        end
        JAMMED: begin
          // Recovery requires the operator to have opened and re-closed the lid.
          if (!lid_closed) lid_opened_d = 1'b1;
          if (lid_opened_q && lid_closed && !jam) begin
            lid_opened_d = 1'b0;
            cnt_clr      = 1'b1;
            state_d      = paper ? COPYING : NO_PAPER;
          end
        end
        NO_PAPER: begin
          if (jam) begin
            state_d = JAMMED;
          end else if (paper && lid_closed) begin
            state_d = COPYING;
            cnt_clr = 1'b1;
          end
        end
        DONE: state_d = IDLE;
        default: begin
          state_d = IDLE;
          rem_d   = '0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  assign state_o   = state_q;
  assign copying   = (state_q == COPYING) && lid_closed;
  assign no_paper  = (state_q == NO_PAPER);
  assign jammed    = (state_q == JAMMED);
  assign done      = (state_q == DONE);
  assign remaining = rem_q;
  assign seg       = seg_of(state_q);

endmodule

// File: tb/tb_copier_ctrl.sv
// Directed bench for copier_ctrl: default instance plus a QTY_W=2 / PAGE_CYCLES=1 instance.
module tb_copier_ctrl;
  import copier_pkg::*;

  logic       clk_2 = 1'b0;
  logic       reset, start, cancel, paper, jam, lid_closed, start2;
  logic [3:0] qty;
  logic [1:0] qty2;

  logic [2:0] state_o, state2;
  logic       copying, no_paper, jammed, done, page_tick;
  logic       copying2, no_paper2, jammed2, done2, page_tick2;
  logic [3:0] remaining;
  logic [1:0] remaining2;
  logic [6:0] seg, seg2;

  int passed = 0;
  int total  = 0;
  int ticks;

  always #5 clk_2 = ~clk_2;

  copier_ctrl #(.QTY_W(4), .PAGE_CYCLES(4)) dut (
    .clk_2(clk_2), .reset(reset), .start(start), .cancel(cancel), .qty(qty),
    .paper(paper), .jam(jam), .lid_closed(lid_closed), .state_o(state_o),
    .copying(copying), .no_paper(no_paper), .jammed(jammed), .done(done),
    .page_tick(page_tick), .remaining(remaining), .seg(seg)
  );

  copier_ctrl #(.QTY_W(2), .PAGE_CYCLES(1)) dut2 (
    .clk_2(clk_2), .reset(reset), .start(start2), .cancel(cancel), .qty(qty2),
    .paper(paper), .jam(jam), .lid_closed(lid_closed), .state_o(state2),
    .copying(copying2), .no_paper(no_paper2), .jammed(jammed2), .done(done2),
    .page_tick(page_tick2), .remaining(remaining2), .seg(seg2)
  );

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; paper = 1'b1; jam = 1'b0;
    lid_closed = 1'b1; qty = '0; start2 = 1'b0; qty2 = '0;
    tick(); tick();
    chk("rst_state", 32'(state_o), 32'(IDLE));
    chk("rst_rem", 32'(remaining), 0);
    chk("rst_tick", 32'(page_tick), 0);
    chk("rst_seg", 32'(seg), 32'(7'b0111111));
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    // 1: three pages, ticks every 4 cycles
    qty = 4'd3; start = 1'b1;
    tick();
    chk("t1_enter", 32'(state_o), 32'(COPYING));
    chk("t1_rem0", 32'(remaining), 3);
    chk("t1_seg", 32'(seg), 32'(7'b0000110));
    chk("t1_copying", 32'(copying), 1);
    start = 1'b0; qty = 4'd9;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("t1_tick", 32'(page_tick), (c % 4 == 0) ? 1 : 0);
      chk("t1_rem", 32'(remaining), 32'(3 - c / 4));
    end
    chk("t1_done_state", 32'(state_o), 32'(DONE));
    chk("t1_done", 32'(done), 1);
    chk("t1_dseg", 32'(seg), 32'(7'b1100110));
    tick();
    chk("t1_idle", 32'(state_o), 32'(IDLE));
    chk("t1_done_off", 32'(done), 0);

    // 2: jam mid-page, recovery needs lid cycle
    qty = 4'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t2_tick1", 32'(page_tick), 1);
    chk("t2_rem4", 32'(remaining), 4);
    tick(); tick();
    jam = 1'b1;
    tick();
    chk("t2_jammed", 32'(state_o), 32'(JAMMED));
    chk("t2_jam_led", 32'(jammed), 1);
    chk("t2_jam_seg", 32'(seg), 32'(7'b1011011));
    chk("t2_jam_rem", 32'(remaining), 4);
    jam = 1'b0;
    tick(); tick(); tick();
    chk("t2_stay", 32'(state_o), 32'(JAMMED));
    lid_closed = 1'b0;
    tick();
    chk("t2_lid_open", 32'(state_o), 32'(JAMMED));
    chk("t2_copying_off", 32'(copying), 0);
    lid_closed = 1'b1;
    tick();
    chk("t2_resume", 32'(state_o), 32'(COPYING));
    ticks = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (page_tick) ticks++;
      if (c == 3) chk("t2_no_early", 32'(page_tick), 0);
    end
    chk("t2_ticks", 32'(ticks), 4);
    chk("t2_done", 32'(done), 1);
    chk("t2_rem_end", 32'(remaining), 0);
    tick();
    chk("t2_idle", 32'(state_o), 32'(IDLE));

    // 3: paper-out mid-page discards the partial page
    qty = 4'd2; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    paper = 1'b0;
    tick();
    chk("t3_nopaper", 32'(state_o), 32'(NO_PAPER));
    chk("t3_np_led", 32'(no_paper), 1);
    chk("t3_np_seg", 32'(seg), 32'(7'b1001111));
    chk("t3_np_rem", 32'(remaining), 2);
    paper = 1'b1;
    tick();
    chk("t3_resume", 32'(state_o), 32'(COPYING));
    tick(); tick(); tick();
    chk("t3_no_early", 32'(page_tick), 0);
    tick();
    chk("t3_tick", 32'(page_tick), 1);
    chk("t3_rem", 32'(remaining), 1);
    tick(); tick(); tick(); tick();
    chk("t3_done", 32'(state_o), 32'(DONE));
    tick();

    // 4: open lid freezes the page counter for exactly 3 cycles
    qty = 4'd1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    lid_closed = 1'b0;
    #1;
    chk("t4_copying_off", 32'(copying), 0);
    tick(); tick(); tick();
    chk("t4_frozen_tick", 32'(page_tick), 0);
    chk("t4_state", 32'(state_o), 32'(COPYING));
    lid_closed = 1'b1;
    tick();
    chk("t4_late", 32'(page_tick), 0);
    tick();
    chk("t4_tick", 32'(page_tick), 1);
    chk("t4_done", 32'(state_o), 32'(DONE));
    tick();

    // 5: cancel beats jam; reset mid-job
    qty = 4'd4; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    jam = 1'b1; cancel = 1'b1;
    tick();
    chk("t5_cancel", 32'(state_o), 32'(IDLE));
    chk("t5_rem", 32'(remaining), 0);
    chk("t5_jam_led", 32'(jammed), 0);
    jam = 1'b0; cancel = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("t5_pre_rst_rem", 32'(remaining), 3);
    reset = 1'b1;
    tick();
    chk("t5_rst_state", 32'(state_o), 32'(IDLE));
    chk("t5_rst_rem", 32'(remaining), 0);
    chk("t5_rst_tick", 32'(page_tick), 0);
    chk("t5_rst_seg", 32'(seg), 32'(7'b0111111));
    reset = 1'b0;

    // 6: qty=0 ignored; single-cycle pages on the narrow instance
    qty = 4'd0; start = 1'b1;
    tick(); tick();
    chk("t6_qty0", 32'(state_o), 32'(IDLE));
    chk("t6_qty0_rem", 32'(remaining), 0);
    start = 1'b0;
    qty2 = 2'd3; start2 = 1'b1;
    tick(); start2 = 1'b0;
    chk("t6_enter", 32'(state2), 32'(COPYING));
    chk("t6_rem3", 32'(remaining2), 3);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("t6_tick", 32'(page_tick2), 1);
      chk("t6_rem", 32'(remaining2), 32'(3 - c));
    end
    chk("t6_done", 32'(done2), 1);
    tick();
    chk("t6_idle", 32'(state2), 32'(IDLE));
    chk("t6_tick_off", 32'(page_tick2), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
